// File: rtl/multi_digit_seg_driver_if.sv
// rtl/multi_digit_seg_driver_if.sv - load/convert request and scanned display bundle
interface multi_digit_seg_driver_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 4
);
    logic              load;
    logic [WIDTH-1:0]  value;
    logic              is_signed;
    logic              blank_lz;
    logic              busy;
    logic              done;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;

    modport master (
        output load, value, is_signed, blank_lz,
        input  busy, done, seg, an
    );

    modport slave (
        input  load, value, is_signed, blank_lz,
        output busy, done, seg, an
    );
endinterface

// File: rtl/multi_digit_seg_driver.sv
// rtl/multi_digit_seg_driver.sv - binary to multiplexed 7-segment driver
// Sequential double-dabble conversion feeding a time-multiplexed, active-low digit scanner.
module multi_digit_seg_driver #(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 1000
) (
    input  logic                    clk,
    input  logic                    resetn,
    multi_digit_seg_driver_if.slave bus
);
    localparam int MW  = WIDTH + 1;
    localparam int NB  = (MW + 2) / 3;
    localparam int DDW = 4 * NB + MW;
    localparam int ND  = (NB > DIGITS) ? NB : DIGITS;
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int RW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW  = $clog2(DIGITS);

    localparam logic [6:0] PAT_MINUS = 7'b0111111;
    localparam logic [6:0] PAT_E     = 7'b0000110;
    localparam logic [6:0] PAT_BLANK = 7'b1111111;

    function automatic logic [6:0] digit_pattern(input logic [3:0] d);
        case (d)
            4'd0:    digit_pattern = 7'b1000000;
            4'd1:    digit_pattern = 7'b1111001;
            4'd2:    digit_pattern = 7'b0100100;
            4'd3:    digit_pattern = 7'b0110000;
            4'd4:    digit_pattern = 7'b0011001;
            4'd5:    digit_pattern = 7'b0010010;
            4'd6:    digit_pattern = 7'b0000010;
            4'd7:    digit_pattern = 7'b1111000;
            4'd8:    digit_pattern = 7'b0000000;
            4'd9:    digit_pattern = 7'b0011000;
            default: digit_pattern = PAT_BLANK;
        endcase
    endfunction

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   shift_cnt;
    logic [DDW-1:0]  dd;
    logic [DDW-1:0]  dd_adj;
    logic [DDW-1:0]  dd_next;
    logic            neg_r;
    logic            done_r;
    logic [RW-1:0]   refresh_cnt;
    logic [SW-1:0]   scan_idx;
    logic [6:0]      pat     [DIGITS];
    logic [6:0]      pat_new [DIGITS];
    logic            accept;
    logic            last_shift;
    logic            neg_in;
    logic [MW-1:0]   mag_in;
    logic [4*ND-1:0] bcd_ext;
    logic            ovf;
    int              avail;
    int              top_nz;

    // Magnitude is one bit wider so the most negative input negates without overflow.
    assign neg_in     = bus.is_signed & bus.value[WIDTH-1];
    assign mag_in     = neg_in ? (~{1'b1, bus.value} + MW'(1)) : {1'b0, bus.value};
    assign accept     = (state == S_IDLE) && bus.load;
    assign last_shift = (state == S_CONV) && (shift_cnt == CW'(WIDTH));

    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (bus.load) state_next = S_CONV;
            S_CONV:  if (last_shift) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        dd_adj = dd;
        for (int k = 0; k < NB; k++) begin
            if (dd[MW + 4*k +: 4] >= 4'd5)
                dd_adj[MW + 4*k +: 4] = dd[MW + 4*k +: 4] + 4'd3;
        end
        dd_next = dd_adj << 1;
    end

    // Formatting works on the post-shift value so the commit lands on the final shift edge.
    always_comb begin
        bcd_ext = '0;
        bcd_ext[4*NB-1:0] = dd_next[DDW-1 -: 4*NB];
        avail  = neg_r ? DIGITS - 1 : DIGITS;
        ovf    = 1'b0;
        top_nz = 0;
        for (int i = 0; i < ND; i++) begin
            if (bcd_ext[4*i +: 4] != 4'd0) begin
                if (i >= avail) ovf = 1'b1;
                else            top_nz = i;
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (ovf)                          pat_new[i] = PAT_E;
            else if (i >= avail)              pat_new[i] = PAT_MINUS;
            else if (bus.blank_lz && i > top_nz) pat_new[i] = PAT_BLANK;
            else                              pat_new[i] = digit_pattern(bcd_ext[4*i +: 4]);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            shift_cnt <= '0;
            dd        <= '0;
            neg_r     <= 1'b0;
            done_r    <= 1'b0;
            for (int i = 0; i < DIGITS; i++)
                pat[i] <= (i == 0) ? digit_pattern(4'd0) : PAT_BLANK;
        end else begin
            done_r <= last_shift;
            if (accept) begin
                dd        <= {{(4*NB){1'b0}}, mag_in};
                neg_r     <= neg_in;
                shift_cnt <= '0;
            end else if (state == S_CONV) begin
                dd        <= dd_next;
                shift_cnt <= shift_cnt + CW'(1);
            end
            if (last_shift) begin
                for (int i = 0; i < DIGITS; i++)
                    pat[i] <= pat_new[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
        end else if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            scan_idx    <= (scan_idx == SW'(DIGITS - 1)) ? '0 : scan_idx + SW'(1);
        end else begin
            refresh_cnt <= refresh_cnt + RW'(1);
        end
    end

    assign bus.busy = (state == S_CONV);
    assign bus.done = done_r;
    assign bus.seg  = pat[scan_idx];
    assign bus.an   = ~({{(DIGITS-1){1'b0}}, 1'b1} << scan_idx);
endmodule

// File: tb/tb_multi_digit_seg_driver.sv
// tb/tb_multi_digit_seg_driver.sv - bench for multi_digit_seg_driver (4-digit and 2-digit instances)
module tb_multi_digit_seg_driver;
    localparam int RD = 4;
    localparam logic [27:0] RST4 = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    localparam logic [13:0] RST2 = {7'h7F, 7'h40};
    localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h18};

    typedef struct {
        logic [7:0]  v;
        bit          sg;
        bit          blz;
        logic [27:0] e4;
        logic [13:0] e2;
    } vec_t;

    logic        clk     = 1'b0;
    logic        resetn  = 1'b0;
    int          ticks   = 0;
    int          nchecks = 0;
    int          nerrors = 0;
    bit          chk_en  = 1'b0;
    logic [27:0] exp4    = RST4;
    logic [13:0] exp2    = RST2;
    vec_t        tab [14];

    multi_digit_seg_driver_if #(.WIDTH(8), .DIGITS(4)) b4 ();
    multi_digit_seg_driver_if #(.WIDTH(8), .DIGITS(2)) b2 ();

    assign b2.load      = b4.load;
    assign b2.value     = b4.value;
    assign b2.is_signed = b4.is_signed;
    assign b2.blank_lz  = b4.blank_lz;

    multi_digit_seg_driver #(.WIDTH(8), .DIGITS(4), .REFRESH_DIV(RD)) dut4 (
        .clk(clk), .resetn(resetn), .bus(b4.slave));
    multi_digit_seg_driver #(.WIDTH(8), .DIGITS(2), .REFRESH_DIV(RD)) dut2 (
        .clk(clk), .resetn(resetn), .bus(b2.slave));

    always #5 clk = ~clk;

    always @(posedge clk) ticks <= resetn ? ticks + 1 : 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        nchecks++;
        if (act !== req) begin
            nerrors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: decimal digits straight from integer arithmetic.
    function automatic logic [27:0] model(input logic [7:0] v, input bit sg, input bit blz, input int nd);
        bit neg;
        int mag, avail, top, p;
        logic [27:0] r;
        neg   = sg && v[7];
        mag   = neg ? 256 - int'(v) : int'(v);
        avail = neg ? nd - 1 : nd;
        r     = '1;
        top   = 0;
        p     = 1;
        for (int i = 0; i < avail; i++) begin
            if ((mag / p) % 10 != 0) top = i;
            p = p * 10;
        end
        if (mag >= p) begin
            for (int i = 0; i < nd; i++) r[i*7 +: 7] = 7'h06;
        end else begin
            p = 1;
            for (int i = 0; i < avail; i++) begin
                r[i*7 +: 7] = (blz && i > top) ? 7'h7F : SEG_TAB[(mag / p) % 10];
                p = p * 10;
            end
            if (neg) r[(nd-1)*7 +: 7] = 7'h3F;
        end
        return r;
    endfunction

    always @(negedge clk) begin : scan_chk
        int s4, s2;
        logic [3:0] an4_e;
        logic [1:0] an2_e;
        if (chk_en) begin
            s4    = (ticks / RD) % 4;
            s2    = (ticks / RD) % 2;
            an4_e = ~(4'b0001 << s4);
            an2_e = ~(2'b01 << s2);
            check("seg4", b4.seg, exp4[s4*7 +: 7]);
            check("an4",  b4.an,  an4_e);
            check("seg2", b2.seg, exp2[s2*7 +: 7]);
            check("an2",  b2.an,  an2_e);
        end
    end

    task automatic do_load(input logic [7:0] v, input bit sg, input bit blz,
                           input logic [27:0] e4, input logic [13:0] e2);
        b4.load = 1'b1; b4.value = v; b4.is_signed = sg; b4.blank_lz = blz;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            b4.load = 1'b0;
            check("busy",       b4.busy, 1);
            check("done_early", b4.done, 0);
            check("busy2",      b2.busy, 1);
        end
        @(posedge clk); #1;
        exp4 = e4; exp2 = e2;
        check("done",     b4.done, 1);
        check("busy_end", b4.busy, 0);
        check("done2",    b2.done, 1);
    endtask

    initial begin
        logic [27:0] m4, m2;
        logic [7:0]  v;
        bit          sg, blz;

        tab[0]  = '{8'd173, 1'b0, 1'b1, {7'h7F, 7'h79, 7'h78, 7'h30}, {7'h06, 7'h06}};
        tab[1]  = '{8'h80,  1'b1, 1'b0, {7'h3F, 7'h79, 7'h24, 7'h00}, {7'h06, 7'h06}};
        tab[2]  = '{8'h80,  1'b0, 1'b0, {7'h40, 7'h79, 7'h24, 7'h00}, {7'h06, 7'h06}};
        tab[3]  = '{8'hFB,  1'b1, 1'b0, {7'h3F, 7'h40, 7'h40, 7'h12}, {7'h3F, 7'h12}};
        tab[4]  = '{8'hFB,  1'b1, 1'b1, {7'h3F, 7'h7F, 7'h7F, 7'h12}, {7'h3F, 7'h12}};
        tab[5]  = '{8'd200, 1'b0, 1'b0, {7'h40, 7'h24, 7'h40, 7'h40}, {7'h06, 7'h06}};
        tab[6]  = '{8'hF6,  1'b1, 1'b1, {7'h3F, 7'h7F, 7'h79, 7'h40}, {7'h06, 7'h06}};
        tab[7]  = '{8'hF7,  1'b1, 1'b1, {7'h3F, 7'h7F, 7'h7F, 7'h18}, {7'h3F, 7'h18}};
        tab[8]  = '{8'd0,   1'b0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h7F, 7'h40}};
        tab[9]  = '{8'd0,   1'b1, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, {7'h40, 7'h40}};
        tab[10] = '{8'd255, 1'b0, 1'b0, {7'h40, 7'h24, 7'h12, 7'h12}, {7'h06, 7'h06}};
        tab[11] = '{8'hFF,  1'b1, 1'b1, {7'h3F, 7'h7F, 7'h7F, 7'h79}, {7'h3F, 7'h79}};
        tab[12] = '{8'd99,  1'b0, 1'b1, {7'h7F, 7'h7F, 7'h18, 7'h18}, {7'h18, 7'h18}};
        tab[13] = '{8'h7F,  1'b1, 1'b1, {7'h7F, 7'h79, 7'h24, 7'h78}, {7'h06, 7'h06}};

        b4.load = 1'b0; b4.value = '0; b4.is_signed = 1'b0; b4.blank_lz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        resetn = 1'b1;
        check("rst_busy", b4.busy, 0);
        check("rst_done", b4.done, 0);
        check("rst_seg",  b4.seg,  7'h40);
        check("rst_an",   b4.an,   4'hE);
        repeat (4) @(posedge clk);
        #1;
        check("an_step", b4.an, 4'hD);

        for (int i = 0; i < 14; i++) begin
            do_load(tab[i].v, tab[i].sg, tab[i].blz, tab[i].e4, tab[i].e2);
            repeat (16) @(posedge clk);
            #1;
        end

        // Load while busy must be dropped; only the first value commits.
        b4.load = 1'b1; b4.value = 8'd42; b4.is_signed = 1'b0; b4.blank_lz = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            b4.load = (k == 3);
            if (k == 3) b4.value = 8'd99;
            check("ign_busy", b4.busy, 1);
            check("ign_done", b4.done, 0);
        end
        @(posedge clk); #1;
        m4 = model(8'd42, 1'b0, 1'b1, 4); m2 = model(8'd42, 1'b0, 1'b1, 2);
        exp4 = m4; exp2 = m2[13:0];
        check("ign_done_pulse", b4.done, 1);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            check("ign_second_done", b4.done, 0);
            check("ign_idle", b4.busy, 0);
        end

        // Reset mid-conversion aborts with no done pulse.
        b4.load = 1'b1; b4.value = 8'hF7; b4.is_signed = 1'b1; b4.blank_lz = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            b4.load = 1'b0;
            check("abort_busy", b4.busy, 1);
        end
        resetn = 1'b0;
        @(posedge clk); #1;
        exp4 = RST4; exp2 = RST2;
        resetn = 1'b1;
        check("abort_busy0", b4.busy, 0);
        check("abort_seg",   b4.seg,  7'h40);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            check("abort_no_done", b4.done, 0);
        end

        for (int n = 0; n < 120; n++) begin
            v   = 8'($urandom);
            sg  = 1'($urandom);
            blz = 1'($urandom);
            m4  = model(v, sg, blz, 4);
            m2  = model(v, sg, blz, 2);
            do_load(v, sg, blz, m4, m2[13:0]);
            if (1'($urandom)) begin
                repeat ($urandom_range(1, 16)) @(posedge clk);
                #1;
            end
        end
        repeat (16) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule

// File: doc/multi_digit_seg_driver.md
MULTI_DIGIT_SEG_DRIVER -- requirements
Module: multi_digit_seg_driver

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the binary input width (legal >= 4).
REQ-002 Parameter DIGITS, default 4, SHALL set the number of display digits (legal >= 2).
REQ-003 Parameter REFRESH_DIV, default 1000, SHALL set the clk cycles per digit scan slot (legal >= 1).
REQ-004 clk  input  1  sole clock; all state SHALL change on its rising edge only.
REQ-005 resetn  input  1  reset; synchronous and active-low.
REQ-006 load  input  1  request to convert value; sampled every cycle.
REQ-007 value  input  WIDTH  binary operand.
REQ-008 is_signed  input  1  1 = value is two's complement, 0 = unsigned; sampled with load.
REQ-009 blank_lz  input  1  1 = blank leading zeros; applied at commit.
REQ-010 busy  output  1  conversion in progress.
REQ-011 done  output  1  one-cycle pulse when new display contents are committed.
REQ-012 seg  output  7  active-low segments {g,f,e,d,c,b,a} of the currently scanned digit.
REQ-013 an  output  DIGITS  active-low one-hot digit enable; bit 0 = rightmost, least significant digit.

Function
REQ-014 Digit patterns SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, minus=0111111, E=0000110, blank=1111111.
REQ-015 load is accepted only in a cycle with load=1 and busy=0; that cycle captures value and is_signed; load while busy=1 SHALL be ignored.
REQ-016 On acceptance, neg = is_signed & value[WIDTH-1]; magnitude = neg ? two's-complement negation of value : value, held in WIDTH+1 bits so the most negative value converts correctly.
REQ-017 Conversion SHALL be sequential double-dabble: NB = ceil((WIDTH+1)/3) BCD digits, one shift per cycle with add-3 on any digit >= 5 before each shift.
REQ-018 With acceptance in cycle T: busy=1 in cycles T+1..T+WIDTH+1; in cycle T+WIDTH+2, busy=0 and done=1, and the display registers hold the new contents.
REQ-019 Available numeric digits: A = DIGITS-1 if neg, else DIGITS.
REQ-020 Overflow: if any BCD digit at index >= A is nonzero, all DIGITS positions SHALL show E and no minus is shown.
REQ-021 Otherwise digit i (i < A) shows BCD digit i, and digit DIGITS-1 shows minus when neg=1.
REQ-022 When blank_lz=1, numeric zeros left of the most significant nonzero digit SHALL be blank; digit 0 SHALL never be blanked; the minus position is unaffected.
REQ-023 Scan: a refresh counter counts 0..REFRESH_DIV-1; on its wrap the scan index advances by one, DIGITS-1 wraps to 0.
REQ-024 an SHALL drive low only bit scan index; seg shows that digit's committed pattern in the same cycle.
REQ-025 Scanning SHALL continue during conversion and show the previously committed contents; commit SHALL update all digits on a single edge, never partially.
REQ-026 A load asserted in the done cycle SHALL be accepted, since busy=0 in that cycle.

Reset
REQ-027 resetn=0 at a clk edge SHALL set: busy=0, done=0, refresh counter=0, scan index=0, digit 0 content=0, all other digits blank, so that seg=1000000 and an=~1 (only bit 0 low).
REQ-028 Reset during a conversion SHALL abort it with no done pulse; the display SHALL return to the REQ-027 contents.

Verification (WIDTH=8, DIGITS=4, REFRESH_DIV=4 unless stated)
REQ-029 Release reset -> seg=1000000, an=1110, busy=0; an advances to 1101 after 4 cycles.
REQ-030 load value=173, is_signed=0, blank_lz=1 at T -> busy in T+1..T+9, done at T+10; digits 3..0 = blank,1,7,3; slot 0 shows seg=0110000, slot 3 shows seg=1111111.
REQ-031 load value=8'h80, is_signed=1 -> digits = minus,1,2,8; repeat with is_signed=0 -> 0,1,2,8 (blank_lz=0).
REQ-032 value=8'hFB, is_signed=1, blank_lz=0 -> minus,0,0,5; with blank_lz=1 -> minus,blank,blank,5.
REQ-033 DIGITS=2: value=200 unsigned -> E,E; value=8'hF6 (-10) signed -> E,E; value=8'hF7 (-9) signed -> minus,9.
REQ-034 load pulsed at T+3 of a busy conversion -> ignored, one done only; resetn=0 at T+5 -> no done, display returns to reset contents.
